// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin two-master arbiter for one block-RAM wrapper port
module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_re,
    input  logic [3:0]            m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_din,
    output logic [31:0]           m0_dout,
    output logic                  m0_dready,
    input  logic                  m1_re,
    input  logic [3:0]            m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_din,
    output logic [31:0]           m1_dout,
    output logic                  m1_dready,
    output logic                  s_re,
    output logic [3:0]            s_we,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [31:0]           s_din,
    input  logic [31:0]           s_dout,
    input  logic                  s_dready,
    output logic                  timeout_err,
    output logic [1:0]            grant
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY0 = 2'd1;
    localparam logic [1:0] S_BUSY1 = 2'd2;

    localparam int              CNT_W    = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic            WDOG_EN  = (TIMEOUT != 0);

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [1:0]       grant_q, grant_d;

    logic req0, req1, own_req, stall;

    assign req0    = m0_re | (|m0_we);
    assign req1    = m1_re | (|m1_we);
    assign own_req = (state_q == S_BUSY1) ? req1 : req0;
    assign stall   = own_req & ~s_dready;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // last_q == 1 means m1 was served last, so m0 wins a tie
                if (req0 && (!req1 || last_q)) begin
                    state_d = S_BUSY0;
                end else if (req1) begin
                    state_d = S_BUSY1;
                end
            end
            S_BUSY0, S_BUSY1: begin
                if (WDOG_EN && stall && (cnt_q == CNT_LAST)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    last_d  = (state_q == S_BUSY1);
                end else if (!own_req && !s_dready) begin
                    state_d = S_IDLE;
                    last_d  = (state_q == S_BUSY1);
                end else if (WDOG_EN && stall) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        grant_d = {state_d == S_BUSY1, state_d == S_BUSY0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            grant_q <= grant_d;
        end
    end

    // Slave-side signals are decoded from state so reset silences them at once
    always_comb begin
        s_re      = 1'b0;
        s_we      = 4'h0;
        s_addr    = '0;
        s_din     = 32'h0;
        m0_dready = 1'b0;
        m1_dready = 1'b0;
        case (state_q)
            S_BUSY0: begin
                s_re      = m0_re;
                s_we      = m0_we;
                s_addr    = m0_addr;
                s_din     = m0_din;
                m0_dready = s_dready;
            end
            S_BUSY1: begin
                s_re      = m1_re;
                s_we      = m1_we;
                s_addr    = m1_addr;
                s_din     = m1_din;
                m1_dready = s_dready;
            end
            default: ;
        endcase
    end

    assign m0_dout     = s_dout;
    assign m1_dout     = s_dout;
    assign timeout_err = err_q;
    assign grant       = grant_q;

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares one port of the dual-port block-RAM wrapper between two requesters (e.g. instruction fetch and a DMA/data master), each speaking the four-way request/ack handshake. The arbiter grants the port round-robin and holds the grant until the full four-way handshake has closed. It also inserts the mandatory idle cycle between transactions so the wrapper's read-latency counter restarts, and flags a stalled RAM with a watchdog. It sits between the masters and port A or port B of the wrapper.

## Interface
- ADDR_WIDTH, 14, word-address width on all address ports
- TIMEOUT, 255, max cycles in BUSY waiting for slave ack before error; 0 disables the watchdog
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- m0_re, m1_re  in  1  master read request
- m0_we, m1_we  in  4  master byte write enables
- m0_addr, m1_addr  in  ADDR_WIDTH  master address
- m0_din, m1_din  in  32  master write data
- m0_dout, m1_dout  out  32  read data (both = s_dout)
- m0_dready, m1_dready  out  1  master ack
- s_re  out  1  read request to wrapper
- s_we  out  4  byte write enables to wrapper
- s_addr  out  ADDR_WIDTH  address to wrapper
- s_din  out  32  write data to wrapper
- s_dout  in  32  read data from wrapper
- s_dready  in  1  wrapper ack (registered in wrapper)
- timeout_err  out  1  sticky watchdog flag
- grant  out  2  one-hot current owner, 00 when idle

## Operation
- reqN = mN_re | (mN_we != 0).
- States: IDLE, BUSY0, BUSY1.
- IDLE: s_re=0, s_we=0, s_addr=0, s_din=0, both mN_dready=0. Both reqN low: stay. One high: go to its BUSY. Both high: grant the master that is not `last`; `last` is a 1-bit register, reset 1, so m0 wins first.
- BUSYk: s_re/s_we/s_addr/s_din combinationally muxed from master k; mk_dready = s_dready; other master's dready = 0. Exit to IDLE when reqk==0 and s_dready==0, i.e. handshake steps 3 and 4 are complete. `last` is set to k on exit.
- The other master's request is ignored during BUSYk and is held by that master (no drop required).
- IDLE always lasts at least 1 cycle between grants, so s_re/s_we are low for at least 1 cycle and the wrapper delay counter clears.
- Watchdog: an 8-bit-or-wider counter clears on BUSY entry and increments each BUSY cycle while s_dready==0 and reqk==1. If it reaches TIMEOUT, timeout_err is set (sticky until reset). The FSM forces IDLE and mk_dready stays 0. The master must then drop its request; `last` is updated to k as on a normal exit.
- Master changes addr/we/din mid-transaction are passed through unchanged; the protocol forbids them and the arbiter does not check for them.
- reset low (any time, including mid-BUSY): state=IDLE, `last`=1, counter=0, timeout_err=0, grant=00. All s_* outputs and dready outputs are 0 immediately, because they are decoded from state.

## Timing
- Request sampled at edge E: the state is BUSYk after E, and s_* are valid in the cycle following E.
- Read with the wrapper's 2-cycle ack: mk_re rises before edge E. s_dready, and therefore mk_dready, is high after edge E+2, giving 3 cycles from master request to ack.
- Write: mk_dready is high after edge E+1.
- Master drops request before edge F: s_re drops in the same cycle. s_dready falls after F+1, and the state is IDLE after F+1 or later.
- Back-to-back requests from the same master with the other idle: at least 1 IDLE cycle between grants.
- Both requesting continuously: grants alternate 0,1,0,1.
- grant is a registered decode of the state; it has no combinational path from the inputs.

## Test plan
- Reset: hold reset=0 while m0_re=1 and s_dready=1 -> all outputs 0, grant=00. Release -> grant=01 after the first edge.
- Single read: m0_re=1, m0_addr=0x0010, s_dout model=0xDEADBEEF with a 2-cycle ack -> m0_dready high 3 cycles after m0_re rises, m0_dout=0xDEADBEEF. Drop m0_re -> IDLE within 2 cycles.
- Contention: m0_re and m1_we=4'b1111 asserted in the same cycle from reset -> m0 served first. m1 write (addr 0x0020, din 0x12345678) appears on s_* only after an s_re-low cycle; m1_dready is never high while grant=01.
- Fairness: both masters request continuously for 8 transactions -> grant sequence 01,10,01,10,...; every transaction separated by at least 1 cycle with s_re=0 and s_we=0.
- Watchdog: TIMEOUT=4, slave never acks a m1 read -> timeout_err=1 after 4 BUSY cycles, grant=00, m1_dready stays 0, flag stays set through later normal transactions.
- Mid-transaction reset: assert reset during BUSY0 with s_dready=1 -> s_re=0 and m0_dready=0 immediately. After release with m1 requesting, m0 is granted first only if m0 is also requesting.
